// File: rtl/bit_serial_sequencer_if.sv
// Host/core-side signal bundle for the bit-serial program sequencer.
// The sequencer uses the slave modport; the host/core side uses master.
interface bit_serial_sequencer_if #(
   parameter int unsigned AW = 4
);
   logic          i_load_en;
   logic [AW-1:0] i_load_addr;
   logic [10:0]   i_load_data;
   logic          i_run;
   logic          i_abort;
   logic [AW-1:0] i_last;
   logic          i_pcincr;
   logic [2:0]    o_instr;
   logic [7:0]    o_switch;
   logic          o_start;
   logic [AW-1:0] o_pc;
   logic          o_busy;
   logic          o_done;
   logic          o_error;

   modport slave (
      input  i_load_en, i_load_addr, i_load_data, i_run, i_abort, i_last, i_pcincr,
      output o_instr, o_switch, o_start, o_pc, o_busy, o_done, o_error
   );

   modport master (
      output i_load_en, i_load_addr, i_load_data, i_run, i_abort, i_last, i_pcincr,
      input  o_instr, o_switch, o_start, o_pc, o_busy, o_done, o_error
   );
endinterface

// File: rtl/bit_serial_sequencer.sv
// Program sequencer: loadable store, program counter, start/pcincr handshake
// with the bit-serial core, and a watchdog on each instruction.
module bit_serial_sequencer #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   bit_serial_sequencer_if.slave bus
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ADVANCE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pc_inc;
   logic [2:0]    instr_q, instr_d;
   logic [7:0]    switch_q, switch_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [10:0]   store_q [DEPTH];
   logic          load_ok;
   logic [10:0]   run_word;

   assign pc_inc = pc_q + AW'(1);

   // A load and a run in the same cycle: the run sees the freshly written word.
   assign run_word = (bus.i_load_en && (bus.i_load_addr == '0)) ? bus.i_load_data
                                                                : store_q[0];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      switch_d = switch_q;
      done_d   = done_q;
      error_d  = error_q;
      timer_d  = timer_q;
      load_ok  = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            load_ok = bus.i_load_en;
            if (bus.i_run) begin
               state_d             = S_ISSUE;
               pc_d                = '0;
               {instr_d, switch_d} = run_word;
               done_d              = 1'b0;
               error_d             = 1'b0;
            end
         end

         S_ISSUE: begin
            timer_d = '0;
            if (bus.i_abort) begin
               state_d = S_IDLE;
            end else if (bus.i_pcincr) begin
               state_d = S_ADVANCE;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            if (bus.i_abort) begin
               state_d = S_IDLE;
            end else if (bus.i_pcincr) begin
               state_d = S_ADVANCE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end
         end

         S_ADVANCE: begin
            if (bus.i_abort) begin
               state_d = S_IDLE;
            end else if (pc_q == bus.i_last) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // pc_inc wraps naturally at DEPTH, giving the wrap-around run.
               pc_d                = pc_inc;
               {instr_d, switch_d} = store_q[pc_inc];
               state_d             = S_ISSUE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         instr_q  <= '0;
         switch_q <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         switch_q <= switch_d;
         done_q   <= done_d;
         error_q  <= error_d;
         timer_q  <= timer_d;
      end
   end

   // Program store is deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (load_ok) begin
         store_q[bus.i_load_addr] <= bus.i_load_data;
      end
   end

   assign bus.o_instr  = instr_q;
   assign bus.o_switch = switch_q;
   assign bus.o_pc     = pc_q;
   assign bus.o_done   = done_q;
   assign bus.o_error  = error_q;
   assign bus.o_start  = (state_q == S_ISSUE);
   assign bus.o_busy   = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                         (state_q == S_ADVANCE);

endmodule

// File: tb/tb_bit_serial_sequencer.sv
// Self-checking bench for bit_serial_sequencer: a cycle table for load-and-run
// plus directed sequences for timing, watchdog, abort, wrap and async reset.
module tb_bit_serial_sequencer;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   logic [10:0] mem_m [16];

   bit_serial_sequencer_if #(.AW(4)) bus ();

   bit_serial_sequencer #(
      .DEPTH   (16),
      .AW      (4),
      .TIMEOUT (15)
   ) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic [3:0]  addr;
      logic [10:0] data;
      logic        run;
      logic        abort;
      logic [3:0]  last;
      logic        pcincr;
      logic [2:0]  e_instr;
      logic [7:0]  e_sw;
      logic        e_start;
      logic [3:0]  e_pc;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [10:0] d);
      bus.i_load_en   = 1'b1;
      bus.i_load_addr = a;
      bus.i_load_data = d;
      step();
      bus.i_load_en   = 1'b0;
      mem_m[a]        = d;
   endtask

   task automatic wait_start(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (bus.o_start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_start_pc(input logic [3:0] pc, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (bus.o_start && bus.o_pc == pc) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (bus.o_done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   function automatic logic [31:0] outs();
      return {14'd0, bus.o_instr, bus.o_switch, bus.o_start, bus.o_pc,
              bus.o_busy, bus.o_done, bus.o_error};
   endfunction

   initial begin
      bit          ok;
      int          start_mask;
      int          done_off;
      int          nstart;
      int          err_off;
      logic        err_busy;
      logic        err_done;
      logic [3:0]  wrap_pc [4];

      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.i_load_en   = 1'b0;
      bus.i_load_addr = '0;
      bus.i_load_data = '0;
      bus.i_run       = 1'b0;
      bus.i_abort     = 1'b0;
      bus.i_last      = '0;
      bus.i_pcincr    = 1'b0;

      //              ld addr   data     run  ab   last  inc   instr sw     st   pc    bsy  dn   er
      vt[0]  = '{1'b1, 4'd0, 11'h05A, 1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 4'd1, 11'h13C, 1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 4'd0, 11'h000, 1'b1, 1'b0, 4'd1, 1'b0, 3'd0, 8'h5A, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 8'h5A, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 8'h5A, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 8'h5A, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b1, 3'd0, 8'h5A, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd1, 8'h3C, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vt[10] = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vt[11] = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b1, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vt[12] = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b0, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
      vt[13] = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b1, 4'd1, 1'b0, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
      vt[14] = '{1'b0, 4'd0, 11'h000, 1'b0, 1'b0, 4'd1, 1'b1, 3'd1, 8'h3C, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};

      // Reset state
      step();
      step();
      chk("reset_outputs", outs(), 32'h0);
      rst_n = 1'b1;

      // Load and run, cycle by cycle
      for (int i = 0; i < 15; i++) begin
         bus.i_load_en   = vt[i].ld;
         bus.i_load_addr = vt[i].addr;
         bus.i_load_data = vt[i].data;
         bus.i_run       = vt[i].run;
         bus.i_abort     = vt[i].abort;
         bus.i_last      = vt[i].last;
         bus.i_pcincr    = vt[i].pcincr;
         if (vt[i].ld) mem_m[vt[i].addr] = vt[i].data;
         step();
         chk($sformatf("vec%0d", i), outs(),
             {14'd0, vt[i].e_instr, vt[i].e_sw, vt[i].e_start, vt[i].e_pc,
              vt[i].e_busy, vt[i].e_done, vt[i].e_err});
      end
      bus.i_load_en = 1'b0;
      bus.i_abort   = 1'b0;
      bus.i_pcincr  = 1'b0;

      // Fast completion: pcincr held high, four instructions
      for (int i = 0; i < 4; i++) load(4'(i), {3'(i + 2), 8'(8'h11 * i + 8'h01)});
      bus.i_last   = 4'd3;
      bus.i_pcincr = 1'b1;
      bus.i_run    = 1'b1;
      step();
      bus.i_run  = 1'b0;
      start_mask = 0;
      done_off   = 0;
      nstart     = 0;
      for (int off = 1; off <= 12; off++) begin
         if (bus.o_start) begin
            start_mask |= (1 << off);
            chk($sformatf("fast_pc%0d", nstart), {28'd0, bus.o_pc}, 32'(nstart));
            chk($sformatf("fast_word%0d", nstart), {21'd0, bus.o_instr, bus.o_switch},
                {21'd0, mem_m[nstart]});
            nstart++;
         end
         if (bus.o_done && done_off == 0) done_off = off;
         step();
      end
      chk("fast_start_offsets", start_mask, 32'h0AA);
      chk("fast_done_offset", done_off, 9);
      bus.i_pcincr = 1'b0;

      // Watchdog: core never responds
      bus.i_run = 1'b1;
      step();
      bus.i_run = 1'b0;
      chk("wd_start", {31'd0, bus.o_start}, 32'd1);
      err_off  = 0;
      err_busy = 1'b1;
      err_done = 1'b1;
      for (int off = 2; off <= 30; off++) begin
         step();
         if (bus.o_error) begin
            err_off  = off;
            err_busy = bus.o_busy;
            err_done = bus.o_done;
            break;
         end
      end
      chk("wd_error_offset", err_off, 17);
      chk("wd_error_idle", {30'd0, err_busy, err_done}, 32'd0);
      bus.i_run = 1'b1;
      step();
      bus.i_run = 1'b0;
      chk("wd_restart", {26'd0, bus.o_start, bus.o_pc, bus.o_error}, {26'd0, 1'b1, 4'd0, 1'b0});
      bus.i_abort = 1'b1;
      step();
      bus.i_abort = 1'b0;

      // Race: pcincr on the final WAIT cycle beats the watchdog
      bus.i_last = 4'd0;
      bus.i_run  = 1'b1;
      step();
      bus.i_run = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("race_pre", {30'd0, bus.o_busy, bus.o_error}, 32'b10);
      bus.i_pcincr = 1'b1;
      step();
      bus.i_pcincr = 1'b0;
      chk("race_advance", {29'd0, bus.o_busy, bus.o_start, bus.o_error}, 32'b100);
      step();
      chk("race_done", {29'd0, bus.o_busy, bus.o_done, bus.o_error}, 32'b010);

      // Abort in WAIT at pc=2, with a blocked load while busy
      bus.i_last = 4'd3;
      bus.i_run  = 1'b1;
      step();
      bus.i_run = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_start && bus.o_pc == 4'd2) break;
         bus.i_pcincr = bus.o_start;
         step();
      end
      bus.i_pcincr = 1'b0;
      chk("abort_reach_pc2", {30'd0, bus.o_start, bus.o_pc == 4'd2}, 32'b11);
      step();
      bus.i_load_en   = 1'b1;
      bus.i_load_addr = 4'd2;
      bus.i_load_data = 11'h7FF;
      step();
      bus.i_load_en = 1'b0;
      bus.i_abort   = 1'b1;
      bus.i_pcincr  = 1'b1;
      step();
      bus.i_abort  = 1'b0;
      bus.i_pcincr = 1'b0;
      chk("abort_state", {24'd0, bus.o_busy, bus.o_start, bus.o_pc, bus.o_done, bus.o_error},
          {24'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0});
      step();
      chk("abort_stays_idle", {30'd0, bus.o_busy, bus.o_start}, 32'd0);

      // Load and run in the same cycle at address 0
      bus.i_load_en   = 1'b1;
      bus.i_load_addr = 4'd0;
      bus.i_load_data = 11'h3C3;
      bus.i_run       = 1'b1;
      mem_m[0]        = 11'h3C3;
      step();
      bus.i_load_en = 1'b0;
      bus.i_run     = 1'b0;
      chk("loadrun_word", {20'd0, bus.o_start, bus.o_instr, bus.o_switch}, {20'd0, 1'b1, 11'h3C3});
      bus.i_last   = 4'd2;
      bus.i_pcincr = 1'b1;
      wait_start_pc(4'd2, 20, ok);
      chk("rerun_reach_pc2", ok, 1);
      chk("blocked_load_word", {21'd0, bus.o_instr, bus.o_switch}, {21'd0, mem_m[2]});
      wait_done(10, ok);
      chk("rerun_done", {30'd0, ok, bus.o_pc == 4'd2}, 32'b11);

      // Wrap: run to pc=14, then retarget last=1
      bus.i_pcincr = 1'b0;
      for (int i = 0; i < 16; i++) load(4'(i), {3'(i), 8'(8'hA0 + i)});
      bus.i_last   = 4'd15;
      bus.i_pcincr = 1'b1;
      bus.i_run    = 1'b1;
      step();
      bus.i_run = 1'b0;
      wait_start_pc(4'd14, 60, ok);
      chk("wrap_reach14", ok, 1);
      bus.i_last = 4'd1;
      wrap_pc[0] = 4'd14;
      wrap_pc[1] = 4'd15;
      wrap_pc[2] = 4'd0;
      wrap_pc[3] = 4'd1;
      for (int n = 0; n < 4; n++) begin
         if (n > 0) begin
            wait_start(6, ok);
            chk($sformatf("wrap_start%0d", n), ok, 1);
         end
         chk($sformatf("wrap_pc%0d", n), {28'd0, bus.o_pc}, {28'd0, wrap_pc[n]});
         chk($sformatf("wrap_word%0d", n), {21'd0, bus.o_instr, bus.o_switch},
             {21'd0, mem_m[wrap_pc[n]]});
      end
      wait_done(6, ok);
      chk("wrap_done", {29'd0, ok, bus.o_busy, bus.o_pc == 4'd1}, 32'b101);

      // Async reset mid-WAIT at pc=5
      bus.i_last = 4'd15;
      bus.i_run  = 1'b1;
      step();
      bus.i_run = 1'b0;
      chk("rerun_clears_done", {31'd0, bus.o_done}, 32'd0);
      wait_start_pc(4'd5, 30, ok);
      bus.i_pcincr = 1'b0;
      step();
      chk("pre_reset_busy", {27'd0, bus.o_busy, bus.o_pc}, {27'd0, 1'b1, 4'd5});
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", outs(), 32'h0);
      #2;
      rst_n = 1'b1;
      step();
      chk("post_reset_idle", outs(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
